// File: rtl/bcd_to_n_digit_mux_cc.sv
// bcd_to_n_digit_mux_cc: round-robin BCD driver for an N-digit common-cathode 7-segment display.
// Optional feature: define LEADING_ZERO_BLANK_EN to blank leading zero digits (digit 0 always lit).
module bcd_to_n_digit_mux_cc #(
  parameter int DIGITS          = 4,
  parameter int PRESCALE        = 50000,
  parameter int BLANK_CYCLES    = 16,
  parameter bit SEG_ACTIVE_HIGH = 1'b1,
  parameter bit SEL_ACTIVE_HIGH = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [4*DIGITS-1:0]   bcd_in,
  input  logic [DIGITS-1:0]     dp_in,
  output logic [6:0]            segments,
  output logic                  dp,
  output logic [DIGITS-1:0]     digit_sel,
  output logic                  frame_start
);

  localparam int CW = $clog2(PRESCALE);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [CW-1:0]     PRESC_LAST = CW'(PRESCALE - 1);
  localparam logic [CW-1:0]     BLANK_END  = CW'(BLANK_CYCLES);
  localparam logic [IW-1:0]     IDX_LAST   = IW'(DIGITS - 1);
  localparam logic [6:0]        SEG_OFF    = SEG_ACTIVE_HIGH ? 7'h00 : 7'h7F;
  localparam logic              DP_OFF     = !SEG_ACTIVE_HIGH;
  localparam logic [DIGITS-1:0] SEL_OFF    = SEL_ACTIVE_HIGH ? {DIGITS{1'b0}} : {DIGITS{1'b1}};

  logic [CW-1:0]          presc_cnt;
  logic [IW-1:0]          digit_idx;
  logic [DIGITS-1:0][3:0] snap_bcd;
  logic [DIGITS-1:0]      snap_dp;

  logic                   frame_cond;
  logic                   slot_last;
  logic                   in_blank;
  logic                   blank_digit;
  logic [3:0]             cur_nib;
  logic                   cur_dp;
  logic [6:0]             seg_dec;
  logic [DIGITS-1:0]      sel_onehot;

  function automatic logic [6:0] decode_bcd(input logic [3:0] nib);
    case (nib)
      4'd0:    decode_bcd = 7'b0111111;
      4'd1:    decode_bcd = 7'b0000110;
      4'd2:    decode_bcd = 7'b1011011;
      4'd3:    decode_bcd = 7'b1001111;
      4'd4:    decode_bcd = 7'b1100110;
      4'd5:    decode_bcd = 7'b1101101;
      4'd6:    decode_bcd = 7'b1111101;
      4'd7:    decode_bcd = 7'b0000111;
      4'd8:    decode_bcd = 7'b1111111;
      4'd9:    decode_bcd = 7'b1101111;
      default: decode_bcd = 7'b0000000;
    endcase
  endfunction

  assign frame_cond = en && (presc_cnt == '0) && (digit_idx == '0);
  assign slot_last  = (presc_cnt == PRESC_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_cnt <= '0;
      digit_idx <= '0;
    end else if (!en) begin
      presc_cnt <= '0;
      digit_idx <= '0;
    end else if (slot_last) begin
      presc_cnt <= '0;
      digit_idx <= (digit_idx == IDX_LAST) ? '0 : digit_idx + 1'b1;
    end else begin
      presc_cnt <= presc_cnt + 1'b1;
    end
  end

  // The whole word is captured at once so a frame never mixes old and new digits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snap_bcd <= '0;
      snap_dp  <= '0;
    end else if (frame_cond) begin
      snap_bcd <= bcd_in;
      snap_dp  <= dp_in;
    end
  end

  // The snapshot is still stale on the frame-start cycle, so digit 0 reads the inputs directly.
  always_comb begin
    cur_nib = snap_bcd[digit_idx];
    cur_dp  = snap_dp[digit_idx];
    if (frame_cond) begin
      cur_nib = bcd_in[3:0];
      cur_dp  = dp_in[0];
    end
  end

  assign seg_dec    = decode_bcd(cur_nib);
  assign sel_onehot = DIGITS'(1) << digit_idx;

  generate
    if (BLANK_CYCLES == 0) begin : g_no_blank
      assign in_blank = 1'b0;
    end else begin : g_blank
      assign in_blank = (presc_cnt < BLANK_END);
    end
  endgenerate

`ifdef LEADING_ZERO_BLANK_EN
  logic [DIGITS-1:0] upper_zero;

  // upper_zero[k] is set when digit k and every digit above it hold zero.
  always_comb begin
    upper_zero = '0;
    upper_zero[DIGITS-1] = (snap_bcd[DIGITS-1] == 4'd0);
    for (int k = DIGITS - 2; k >= 0; k--) begin
      upper_zero[k] = upper_zero[k+1] && (snap_bcd[k] == 4'd0);
    end
  end

  assign blank_digit = (digit_idx != '0) && upper_zero[digit_idx];
`else
  assign blank_digit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      segments    <= SEG_OFF;
      dp          <= DP_OFF;
      digit_sel   <= SEL_OFF;
      frame_start <= 1'b0;
    end else begin
      frame_start <= frame_cond;
      if (!en) begin
        segments  <= SEG_OFF;
        dp        <= DP_OFF;
        digit_sel <= SEL_OFF;
      end else begin
        segments  <= blank_digit ? SEG_OFF : (SEG_ACTIVE_HIGH ? seg_dec : ~seg_dec);
        dp        <= SEG_ACTIVE_HIGH ? cur_dp : ~cur_dp;
        digit_sel <= in_blank ? SEL_OFF : (SEL_ACTIVE_HIGH ? sel_onehot : ~sel_onehot);
      end
    end
  end

endmodule
